instr_encoder: RTL



---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 52 +++++
 rtl/instr_encoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I field constants and request codes for the instruction encoder.
// Consumed by instr_encoder; no optional features live here.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [1:0] {
    OP_LW  = 2'd0,
    OP_SW  = 2'd1,
    OP_BEQ = 2'd2,
    OP_R   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_e;

  // ADD and SUB share funct3; funct7 is what tells them apart.
  function automatic logic [2:0] aluFunct3(input logic [1:0] alu);
    logic [2:0] f3;
    f3 = F3_ADD_SUB;
    case (alu)
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      default: f3 = F3_ADD_SUB;
    endcase
    return f3;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and a combinational head.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign head   = mem_q[rdPtr_q[AW-1:0]];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: empty/head gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs LW/SW/BEQ/R-type requests into RV32I words, queues them and streams them with word addresses.
// Define RD_ZERO_CHECK_EN to reject LW and R-type requests that target x0.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [1:0]        in_alu,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  logic [31:0]       encWord;
  logic              legalReq;
  logic              accept, pushReq, rejectReq, popWord;
  logic              fifoFull, fifoEmpty;
  logic [31:0]       fifoHead;
  logic              err_q, err_d;
  logic [7:0]        errCnt_q, errCnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    encWord  = '0;
    legalReq = 1'b1;
    case (in_op)
      OP_LW: begin
        encWord  = {in_imm[11:0], in_rs1, F3_LW, in_rd, OPC_LOAD};
        legalReq = (in_imm[12] == in_imm[11]);
      end
      OP_SW: begin
        encWord  = {in_imm[11:5], in_rs2, in_rs1, F3_SW, in_imm[4:0], OPC_STORE};
        legalReq = (in_imm[12] == in_imm[11]);
      end
      OP_BEQ: begin
        encWord  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
                    in_imm[4:1], in_imm[11], OPC_BRANCH};
        legalReq = !in_imm[0];
      end
      default: begin
        encWord  = {(in_alu == ALU_SUB) ? F7_SUB : F7_BASE, in_rs2, in_rs1,
                    aluFunct3(in_alu), in_rd, OPC_OP};
        legalReq = 1'b1;
      end
    endcase
`ifdef RD_ZERO_CHECK_EN
    if (((in_op == OP_LW) || (in_op == OP_R)) && (in_rd == 5'd0)) legalReq = 1'b0;
`endif
  end

  // Illegal requests are still handshaken so the producer never stalls on them.
  assign in_ready  = !fifoFull;
  assign accept    = in_valid && in_ready;
  assign pushReq   = accept && legalReq;
  assign rejectReq = accept && !legalReq;
  assign out_valid = !fifoEmpty;
  assign popWord   = out_valid && out_ready;
  assign out_instr = fifoEmpty ? 32'd0 : fifoHead;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_cnt   = errCnt_q;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushReq),
    .pushData (encWord),
    .pop      (popWord),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (fifoHead)
  );

  always_comb begin
    err_d    = rejectReq;
    errCnt_d = errCnt_q;
    addr_d   = addr_q;
    if (rejectReq && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
    if (popWord) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      errCnt_q <= '0;
      addr_q   <= '0;
    end else begin
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
      addr_q   <= addr_d;
    end
  end

endmodule
